n64_poll_scheduler: RTL

//  Sequences the N64Controller serial engine for the ping-pong game: issues a one-cycle

---
 rtl/n64_poll_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/n64_poll_scheduler.sv
// n64_poll_scheduler: periodically polls the N64Controller serial engine and
// decodes the controller response into buttons, stick values and paddle motion
// for the ping-pong game. It also counts missed polls and tracks link health.
//
// Ports:
//   clk, rst          clock and async active-high reset
//   enable            1 = scheduling active
//   ctrl_start        one-cycle start pulse to the serial engine
//   ctrl_poll_enable  registered copy of enable
//   ctrl_data         34-bit engine response (bits 33:32 unused)
//   ctrl_read_valid   engine readValid level
//   buttons/stick_x/stick_y  latched response fields
//   sample_valid      one-cycle pulse when a new sample is latched
//   paddle_up/down    paddle motion derived from D-pad and stick_y
//   link_ok           1 after a good sample, 0 after MAX_MISSES consecutive misses
//   miss_count        total missed polls, saturating
module n64_poll_scheduler #(
  parameter int unsigned POLL_PERIOD = 200000,
  parameter int unsigned TIMEOUT     = 20000,
  parameter int unsigned MAX_MISSES  = 3,
  parameter int          DEADZONE    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        ctrl_start,
  output logic        ctrl_poll_enable,
  input  logic [33:0] ctrl_data,
  input  logic        ctrl_read_valid,
  output logic [15:0] buttons,
  output logic [7:0]  stick_x,
  output logic [7:0]  stick_y,
  output logic        sample_valid,
  output logic        paddle_up,
  output logic        paddle_down,
  output logic        link_ok,
  output logic [7:0]  miss_count
);

  localparam int unsigned PeriodW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned TimeoutW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned MissW    = 8;

  localparam logic [PeriodW-1:0]  PeriodLast  = PeriodW'(POLL_PERIOD - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);
  localparam logic [MissW-1:0]    MissLimit   = MissW'(MAX_MISSES);
  localparam logic [MissW-1:0]    MissMax     = '1;

  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} stateType;

  stateType             state, nextState;
  logic [PeriodW-1:0]   periodCount;
  logic [TimeoutW-1:0]  timeoutCount;
  logic                 readValidPrev;
  logic [MissW-1:0]     consecMisses;

  logic tick, readValidRise;
  logic startNext, clearTimeout, incTimeout, doCapture, doMiss;
  logic [MissW-1:0] consecNext;
  logic dropLink;
  logic signed [7:0] capStickY;
  logic capUp, capDown;

  logic unusedDataHi;
  assign unusedDataHi = ^ctrl_data[33:32];

  assign tick          = enable && (periodCount == PeriodLast);
  assign readValidRise = ctrl_read_valid && !readValidPrev;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and control decode; dropping enable aborts any poll in flight
  always_comb begin
    nextState    = state;
    startNext    = 1'b0;
    clearTimeout = 1'b0;
    incTimeout   = 1'b0;
    doCapture    = 1'b0;
    doMiss       = 1'b0;
    if (!enable) begin
      nextState    = IDLE;
      clearTimeout = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            nextState = START;
            startNext = 1'b1;
          end
        end
        START: begin
          nextState    = WAIT;
          clearTimeout = 1'b1;
        end
        WAIT: begin
          // An edge on the final timeout cycle still counts as a capture
          if (readValidRise) begin
            nextState = CAPTURE;
          end else if (timeoutCount == TimeoutLast) begin
            nextState = IDLE;
            doMiss    = 1'b1;
          end else begin
            incTimeout = 1'b1;
          end
        end
        CAPTURE: begin
          nextState = IDLE;
          doCapture = 1'b1;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Decode of the incoming response and miss bookkeeping
  always_comb begin
    capStickY  = ctrl_data[31:24];
    capUp      = ctrl_data[11] || (int'(capStickY) > DEADZONE);
    capDown    = ctrl_data[10] || (int'(capStickY) < -DEADZONE);
    consecNext = (consecMisses == MissMax) ? consecMisses : consecMisses + MissW'(1);
    dropLink   = (consecNext >= MissLimit);
  end

  // Counters, edge detect and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periodCount      <= '0;
      timeoutCount     <= '0;
      readValidPrev    <= 1'b0;
      consecMisses     <= '0;
      ctrl_start       <= 1'b0;
      ctrl_poll_enable <= 1'b0;
      buttons          <= '0;
      stick_x          <= '0;
      stick_y          <= '0;
      sample_valid     <= 1'b0;
      paddle_up        <= 1'b0;
      paddle_down      <= 1'b0;
      link_ok          <= 1'b0;
      miss_count       <= '0;
    end else begin
      if (!enable || (periodCount == PeriodLast)) periodCount <= '0;
      else                                         periodCount <= periodCount + PeriodW'(1);

      if (clearTimeout)    timeoutCount <= '0;
      else if (incTimeout) timeoutCount <= timeoutCount + TimeoutW'(1);

      readValidPrev    <= ctrl_read_valid;
      ctrl_start       <= startNext;
      ctrl_poll_enable <= enable;
      sample_valid     <= doCapture;

      if (doCapture) begin
        buttons      <= ctrl_data[15:0];
        stick_x      <= ctrl_data[23:16];
        stick_y      <= ctrl_data[31:24];
        paddle_up    <= capUp && !capDown;
        paddle_down  <= capDown && !capUp;
        link_ok      <= 1'b1;
        consecMisses <= '0;
      end else if (doMiss) begin
        if (miss_count != MissMax) miss_count <= miss_count + MissW'(1);
        consecMisses <= consecNext;
        if (dropLink) begin
          link_ok     <= 1'b0;
          buttons     <= '0;
          stick_x     <= '0;
          stick_y     <= '0;
          paddle_up   <= 1'b0;
          paddle_down <= 1'b0;
        end
      end
    end
  end

endmodule
